// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, 10-bit frame
// clocked out on device falling edges, ACK sample, with a watchdog on the device phase.
module ps2_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter int unsigned DEB_BITS       = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       tx_busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        RELEASE
    } state_t;

    state_t              state;
    logic [1:0]          clk_s;
    logic [1:0]          data_s;
    logic [DEB_BITS-1:0] deb_cnt;
    logic                clk_f;
    logic                clk_prev;
    logic                fall;
    logic [9:0]          frame;
    logic [3:0]          bit_cnt;
    logic [INH_W-1:0]    inh_cnt;
    logic [WD_W-1:0]     wd_cnt;
    logic                ack_err;

    // Synchronisers plus a filter that only follows the clock after 2^DEB_BITS differing samples in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s    <= '1;
            data_s   <= '1;
            deb_cnt  <= '0;
            clk_f    <= 1'b1;
            clk_prev <= 1'b1;
        end else begin
            clk_s    <= {clk_s[0], ps2_clk_in};
            data_s   <= {data_s[0], ps2_data_in};
            clk_prev <= clk_f;
            if (clk_s[1] == clk_f) begin
                deb_cnt <= '0;
            end else if (deb_cnt == '1) begin
                clk_f   <= clk_s[1];
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_BITS'(1);
            end
        end
    end

    assign fall = clk_prev & ~clk_f;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            frame       <= '0;
            bit_cnt     <= '0;
            inh_cnt     <= '0;
            wd_cnt      <= '0;
            ack_err     <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
            tx_busy     <= 1'b0;
            tx_ready    <= 1'b1;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        frame      <= {1'b1, ~^tx_data, tx_data};
                        inh_cnt    <= '0;
                        ps2_clk_oe <= 1'b1;
                        tx_ready   <= 1'b0;
                        tx_busy    <= 1'b1;
                        state      <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    // Clock release and start bit share the last inhibit edge so the pull lasts exactly INHIBIT_CYCLES.
                    if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b1;
                        wd_cnt      <= '0;
                        state       <= RTS;
                    end else begin
                        inh_cnt <= inh_cnt + INH_W'(1);
                    end
                end
                RTS: begin
                    // Watchdog was cleared at clock release; this cycle already counts toward the timeout.
                    bit_cnt <= '0;
                    wd_cnt  <= wd_cnt + WD_W'(1);
                    state   <= SEND;
                end
                SEND, ACK: begin
                    if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_done     <= 1'b1;
                        tx_err      <= 1'b1;
                        tx_ready    <= 1'b1;
                        tx_busy     <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                        if (fall) begin
                            if (state == SEND) begin
                                ps2_data_oe <= ~frame[bit_cnt];
                                if (bit_cnt == 4'd9) begin
                                    state <= ACK;
                                end else begin
                                    bit_cnt <= bit_cnt + 4'd1;
                                end
                            end else begin
                                ps2_data_oe <= 1'b0;
                                ack_err     <= data_s[1];
                                state       <= RELEASE;
                            end
                        end
                    end
                end
                RELEASE: begin
                    if (clk_f && data_s[1]) begin
                        tx_done  <= 1'b1;
                        tx_err   <= ack_err;
                        tx_ready <= 1'b1;
                        tx_busy  <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx: a behavioural PS/2 device clocks frames out of the host and ACKs (or not).
module tb_ps2_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_err, tx_busy;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk = 1'b1;
    logic       dev_data_low = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic done_err = 1'b0;

    // Open-drain lines: low if either side pulls.
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = ~ps2_data_oe & ~dev_data_low;

    ps2_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(2000), .DEB_BITS(3)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_done(tx_done), .tx_err(tx_err), .tx_busy(tx_busy),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (tx_done) begin
            done_cnt++;
            done_err = tx_err;
            done_cyc = cyc;
        end
    end

    task automatic start_frame(input logic [7:0] b, output int rel_cyc);
        int hi = 0;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!ps2_clk_oe) break;
            hi++;
            @(negedge clk);
        end
        rel_cyc = cyc;
        checks++; if (hi !== 20) begin errors++; $display("FAIL inhibit_len: got %0d want 20", hi); end
        checks++; if (ps2_data_oe !== 1'b1) begin errors++; $display("FAIL start_bit: data_oe=%b want 1", ps2_data_oe); end
        checks++; if (tx_busy !== 1'b1 || tx_ready !== 1'b0) begin errors++; $display("FAIL busy_flags: busy=%b ready=%b want 1/0", tx_busy, tx_ready); end
    endtask

    task automatic dev_frame(input int nedges, input bit ack_low, input int glitch_bit,
                             input int inject_bit, output logic [9:0] bits);
        bits = '0;
        for (int k = 0; k < nedges && k < 10; k++) begin
            dev_clk = 1'b0;
            repeat (20) @(negedge clk);
            dev_clk = 1'b1;
            bits[k] = ~ps2_data_oe;
            if (k == glitch_bit) begin
                repeat (12) @(negedge clk);
                dev_clk = 1'b0;
                repeat (5) @(negedge clk);
                dev_clk = 1'b1;
                repeat (3) @(negedge clk);
            end else if (k == inject_bit) begin
                repeat (5) @(negedge clk);
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
                repeat (14) @(negedge clk);
            end else begin
                repeat (20) @(negedge clk);
            end
        end
        if (nedges > 10) begin
            dev_data_low = ack_low;
            repeat (10) @(negedge clk);
            dev_clk = 1'b0;
            repeat (20) @(negedge clk);
            dev_clk = 1'b1;
            repeat (20) @(negedge clk);
            dev_data_low = 1'b0;
        end
    endtask

    task automatic wait_done(input int prev, input int budget, input string tag);
        int i;
        for (i = 0; i < budget; i++) begin
            if (done_cnt != prev) break;
            @(negedge clk);
        end
        checks++; if (done_cnt != prev + 1) begin errors++; $display("FAIL %s_done: done pulses=%0d want 1", tag, done_cnt - prev); end
    endtask

    task automatic check_idle(input string tag);
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: clk_oe=%b data_oe=%b ready=%b busy=%b want 0 0 1 0", tag, ps2_clk_oe, ps2_data_oe, tx_ready, tx_busy);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit ack_low, input int glitch_bit,
                              input int inject_bit, input logic [9:0] exp_bits, input string tag);
        int rel, prev;
        logic [9:0] bits;
        start_frame(b, rel);
        repeat (40) @(negedge clk);
        prev = done_cnt;
        dev_frame(11, ack_low, glitch_bit, inject_bit, bits);
        wait_done(prev, 200, tag);
        checks++; if (bits !== exp_bits) begin errors++; $display("FAIL %s_bits: got %h want %h", tag, bits, exp_bits); end
        checks++; if (done_err !== ~ack_low) begin errors++; $display("FAIL %s_err: got %b want %b", tag, done_err, ~ack_low); end
        repeat (2) @(negedge clk);
        check_idle(tag);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_done !== 1'b0 || tx_err !== 1'b0 ||
            tx_busy !== 1'b0 || tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: clk_oe=%b data_oe=%b done=%b err=%b busy=%b ready=%b",
                     ps2_clk_oe, ps2_data_oe, tx_done, tx_err, tx_busy, tx_ready);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_send_bytes;
        send_frame(8'hED, 1'b1, -1, -1, 10'h3ED, "send_ed");
        send_frame(8'h00, 1'b1, -1, -1, 10'h300, "send_00");
    endtask

    task automatic test_nack;
        send_frame(8'hA5, 1'b0, -1, -1, 10'h3A5, "nack");
        repeat (30) @(negedge clk);
        checks++; if (tx_err !== 1'b1) begin errors++; $display("FAIL err_hold: tx_err=%b want 1", tx_err); end
        send_frame(8'h07, 1'b1, -1, -1, 10'h207, "send_07");
        checks++; if (tx_err !== 1'b0) begin errors++; $display("FAIL err_clear: tx_err=%b want 0", tx_err); end
    endtask

    task automatic test_timeout;
        int rel, prev;
        start_frame(8'h12, rel);
        prev = done_cnt;
        wait_done(prev, 3000, "timeout");
        checks++; if (done_cyc - rel !== 2000) begin errors++; $display("FAIL timeout_len: got %0d want 2000", done_cyc - rel); end
        checks++; if (done_err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b want 1", done_err); end
        @(negedge clk);
        check_idle("timeout");
    endtask

    task automatic test_busy_ignore;
        int prev;
        prev = done_cnt;
        send_frame(8'h3C, 1'b1, -1, 3, 10'h33C, "busy_ignore");
        repeat (50) @(negedge clk);
        checks++; if (done_cnt !== prev + 1) begin errors++; $display("FAIL busy_ignore_count: got %0d want 1", done_cnt - prev); end
        check_idle("busy_ignore_after");
    endtask

    task automatic test_glitch;
        send_frame(8'h81, 1'b1, 4, -1, 10'h381, "glitch");
    endtask

    task automatic test_reset_mid;
        int rel;
        logic [9:0] bits;
        start_frame(8'h00, rel);
        repeat (40) @(negedge clk);
        dev_frame(3, 1'b0, -1, -1, bits);
        checks++; if (ps2_data_oe !== 1'b1) begin errors++; $display("FAIL mid_data_low: data_oe=%b want 1", ps2_data_oe); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin errors++; $display("FAIL async_release: clk_oe=%b data_oe=%b want 0 0", ps2_clk_oe, ps2_data_oe); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_idle("reset_mid");
    endtask

    initial begin
        test_reset;
        test_send_bytes;
        test_nack;
        test_timeout;
        test_busy_ignore;
        test_glitch;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
